// File: rtl/sprite_pkg.sv
// Shared types and geometry for the sprite loader and its bank RAM.
package sprite_pkg;

  localparam int SPR_W          = 32;
  localparam int SPR_H          = 32;
  localparam int PIX_W          = 4;
  localparam int FRAME_BITS     = 4;

  localparam int X_BITS         = $clog2(SPR_W);
  localparam int Y_BITS         = $clog2(SPR_H);
  localparam int PIX_ADDR_BITS  = X_BITS + Y_BITS;
  localparam int PIX_COUNT      = SPR_W * SPR_H;
  localparam int ROM_ADDR_BITS  = 2 + FRAME_BITS + PIX_ADDR_BITS;
  localparam int BANK_ADDR_BITS = PIX_ADDR_BITS + 1;
  localparam int FRAME_SLOTS    = 1 << FRAME_BITS;

  // Encoding shared with the character animation FSM.
  typedef enum logic [1:0] {
    STAND  = 2'd0,
    ATTACK = 2'd1,
    MOVEL  = 2'd2,
    MOVER  = 2'd3
  } anim_state_t;

  typedef enum logic [1:0] {
    LD_IDLE,
    LD_ISSUE,
    LD_DRAIN,
    LD_WAIT_SWAP
  } load_state_t;

  function automatic logic state_out_of_range(input logic [7:0] req);
    return req > 8'd3;
  endfunction

  function automatic logic frame_out_of_range(input logic [7:0] req);
    return req >= 8'(FRAME_SLOTS);
  endfunction

  // Out-of-range states fall back to STAND.
  function automatic anim_state_t clamp_state(input logic [7:0] req);
    return state_out_of_range(req) ? STAND : anim_state_t'(req[1:0]);
  endfunction

  // Out-of-range frames fall back to frame 0.
  function automatic logic [FRAME_BITS-1:0] clamp_frame(input logic [7:0] req);
    return frame_out_of_range(req) ? '0 : req[FRAME_BITS-1:0];
  endfunction

endpackage

// File: rtl/sprite_bank_ram.sv
// Simple dual-port RAM holding both sprite banks; bank bit is the address MSB.
module sprite_bank_ram
  import sprite_pkg::*;
#(
  parameter int ADDR_W = BANK_ADDR_BITS,
  parameter int DATA_W = PIX_W
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [2**ADDR_W];
  logic [DATA_W-1:0] rd_data_q;

  // Loader writes the back bank while the renderer reads the display bank.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    rd_data_q <= mem[rd_addr];
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/character_sprite_loader.sv
// Streams the requested sprite from ROM into the back bank, then swaps banks on a frame edge.
module character_sprite_loader
  import sprite_pkg::*;
#(
  parameter int ROM_LAT = 2
) (
  input  logic                     Clk,
  input  logic                     Reset_n,
  input  logic                     frame_clk,
  input  logic [7:0]               req_state,
  input  logic [7:0]               req_frame,
  output logic [ROM_ADDR_BITS-1:0] rom_addr,
  output logic                     rom_rd,
  input  logic [PIX_W-1:0]         rom_data,
  input  logic [X_BITS-1:0]        rd_x,
  input  logic [Y_BITS-1:0]        rd_y,
  output logic [PIX_W-1:0]         rd_pix,
  output logic                     frame_valid,
  output logic [1:0]               disp_state,
  output logic [FRAME_BITS-1:0]    disp_frame,
  output logic                     busy,
  output logic                     err_clamp
);

  logic fclk_q, fclk_dly_q, edge_q, edge_d;

  load_state_t              state_q, state_d;
  logic [PIX_ADDR_BITS-1:0] cnt_q, cnt_d, cnt_inc;
  logic                     rom_rd_q, rom_rd_d;
  logic [ROM_ADDR_BITS-1:0] rom_addr_q, rom_addr_d;
  anim_state_t              pend_state_q, pend_state_d;
  logic [FRAME_BITS-1:0]    pend_frame_q, pend_frame_d;
  anim_state_t              disp_state_q, disp_state_d;
  logic [FRAME_BITS-1:0]    disp_frame_q, disp_frame_d;
  logic                     frame_valid_q, frame_valid_d;
  logic                     bank_q, bank_d;
  logic                     busy_q, busy_d;
  logic                     err_q, err_d;

  anim_state_t              req_state_c;
  logic [FRAME_BITS-1:0]    req_frame_c;
  logic                     req_bad;

  logic [ROM_LAT-1:0]       vld_q, vld_d;
  logic [PIX_ADDR_BITS-1:0] dl_addr_q [ROM_LAT];
  logic [PIX_ADDR_BITS-1:0] dl_addr_d [ROM_LAT];

  logic                     rd_en_q;
  logic [PIX_W-1:0]         ram_rd_data;

  // Registered rising-edge detect of the frame clock.
  always_comb edge_d = fclk_q & ~fclk_dly_q;

  // Frame-clock sampling and edge pulse flops.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      fclk_q     <= 1'b0;
      fclk_dly_q <= 1'b0;
      edge_q     <= 1'b0;
    end else begin
      fclk_q     <= frame_clk;
      fclk_dly_q <= fclk_q;
      edge_q     <= edge_d;
    end
  end

  // Clamp the live request so it can be captured on any sampling edge.
  always_comb begin
    req_state_c = clamp_state(req_state);
    req_frame_c = clamp_frame(req_frame);
    req_bad     = state_out_of_range(req_state) | frame_out_of_range(req_frame);
  end

  // Loader next-state: request capture, ROM issue sequencing and bank swap.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    cnt_inc       = cnt_q + 1'b1;
    rom_rd_d      = 1'b0;
    rom_addr_d    = rom_addr_q;
    pend_state_d  = pend_state_q;
    pend_frame_d  = pend_frame_q;
    disp_state_d  = disp_state_q;
    disp_frame_d  = disp_frame_q;
    frame_valid_d = frame_valid_q;
    bank_d        = bank_q;
    err_d         = err_q;
    unique case (state_q)
      LD_IDLE: begin
        if (edge_q) begin
          pend_state_d = req_state_c;
          pend_frame_d = req_frame_c;
          err_d        = err_q | req_bad;
          if (!(frame_valid_q && req_state_c == disp_state_q && req_frame_c == disp_frame_q)) begin
            state_d    = LD_ISSUE;
            cnt_d      = '0;
            rom_rd_d   = 1'b1;
            rom_addr_d = {req_state_c, req_frame_c, {PIX_ADDR_BITS{1'b0}}};
          end
        end
      end
      LD_ISSUE: begin
        if (cnt_q == PIX_ADDR_BITS'(PIX_COUNT - 1)) begin
          state_d = LD_DRAIN;
        end else begin
          cnt_d      = cnt_inc;
          rom_rd_d   = 1'b1;
          rom_addr_d = {pend_state_q, pend_frame_q, cnt_inc};
        end
      end
      LD_DRAIN: begin
        if (vld_q == '0 && !rom_rd_q) state_d = LD_WAIT_SWAP;
      end
      LD_WAIT_SWAP: begin
        if (edge_q) begin
          bank_d        = ~bank_q;
          disp_state_d  = pend_state_q;
          disp_frame_d  = pend_frame_q;
          frame_valid_d = 1'b1;
          pend_state_d  = req_state_c;
          pend_frame_d  = req_frame_c;
          err_d         = err_q | req_bad;
          if (req_state_c == pend_state_q && req_frame_c == pend_frame_q) begin
            state_d = LD_IDLE;
          end else begin
            state_d    = LD_ISSUE;
            cnt_d      = '0;
            rom_rd_d   = 1'b1;
            rom_addr_d = {req_state_c, req_frame_c, {PIX_ADDR_BITS{1'b0}}};
          end
        end
      end
      default: state_d = LD_IDLE;
    endcase
    busy_d = (state_d != LD_IDLE);
  end

  // Loader FSM and its registered outputs.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q       <= LD_IDLE;
      cnt_q         <= '0;
      rom_rd_q      <= 1'b0;
      rom_addr_q    <= '0;
      pend_state_q  <= STAND;
      pend_frame_q  <= '0;
      disp_state_q  <= STAND;
      disp_frame_q  <= '0;
      frame_valid_q <= 1'b0;
      bank_q        <= 1'b0;
      busy_q        <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      rom_rd_q      <= rom_rd_d;
      rom_addr_q    <= rom_addr_d;
      pend_state_q  <= pend_state_d;
      pend_frame_q  <= pend_frame_d;
      disp_state_q  <= disp_state_d;
      disp_frame_q  <= disp_frame_d;
      frame_valid_q <= frame_valid_d;
      bank_q        <= bank_d;
      busy_q        <= busy_d;
      err_q         <= err_d;
    end
  end

  // Delay line pairing each ROM beat with the pixel offset it was issued for.
  always_comb begin
    vld_d[0]     = rom_rd_q;
    dl_addr_d[0] = rom_addr_q[PIX_ADDR_BITS-1:0];
    for (int i = 1; i < ROM_LAT; i++) begin
      vld_d[i]     = vld_q[i-1];
      dl_addr_d[i] = dl_addr_q[i-1];
    end
  end

  // Delay-line flops; clearing valid on reset drops any beats still in flight.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      vld_q <= '0;
      for (int i = 0; i < ROM_LAT; i++) dl_addr_q[i] <= '0;
    end else begin
      vld_q <= vld_d;
      for (int i = 0; i < ROM_LAT; i++) dl_addr_q[i] <= dl_addr_d[i];
    end
  end

  // Remember whether the display bank was valid when the read was presented.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) rd_en_q <= 1'b0;
    else          rd_en_q <= frame_valid_q;
  end

  sprite_bank_ram #(
    .ADDR_W (BANK_ADDR_BITS),
    .DATA_W (PIX_W)
  ) u_bank_ram (
    .clk     (Clk),
    .wr_en   (vld_q[ROM_LAT-1]),
    .wr_addr ({~bank_q, dl_addr_q[ROM_LAT-1]}),
    .wr_data (rom_data),
    .rd_addr ({bank_q, rd_y, rd_x}),
    .rd_data (ram_rd_data)
  );

  assign rom_rd      = rom_rd_q;
  assign rom_addr    = rom_addr_q;
  assign rd_pix      = rd_en_q ? ram_rd_data : '0;
  assign frame_valid = frame_valid_q;
  assign disp_state  = disp_state_q;
  assign disp_frame  = disp_frame_q;
  assign busy        = busy_q;
  assign err_clamp   = err_q;

endmodule
